// File: rtl/cla16_multiword_seq.sv
// Multi-word adder: streams WORDS 16-bit slices, LSB first, through one cla16 with the carry registered between slices.
// Optional build macro CLA_SEQ_SUB_EN adds a 'sub' input that turns the operation into a - b.

module cla16 (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        carryInput,
   output logic [15:0] sum,
   output logic        carryOutput,
   output logic        prop,
   output logic        gene
);
   logic [15:0] p;
   logic [15:0] g;
   logic [3:0]  grp_p;
   logic [3:0]  grp_g;
   logic [3:0]  grp_c;

   assign p = a ^ b;
   assign g = a & b;

   // Four 4-bit lookahead groups; each group only needs its own carry-in from the second level.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_group
         logic [3:0] gp;
         logic [3:0] gg;
         logic       c_in;
         logic [3:1] c_up;

         assign gp   = p[4*gi +: 4];
         assign gg   = g[4*gi +: 4];
         assign c_in = grp_c[gi];

         assign c_up[1] = gg[0] | (gp[0] & c_in);
         assign c_up[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c_in);
         assign c_up[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                        | (gp[2] & gp[1] & gp[0] & c_in);

         assign grp_p[gi] = &gp;
         assign grp_g[gi] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                          | (gp[3] & gp[2] & gp[1] & gg[0]);

         assign sum[4*gi +: 4] = gp ^ {c_up, c_in};
      end
   endgenerate

   assign grp_c[0] = carryInput;
   assign grp_c[1] = grp_g[0] | (grp_p[0] & carryInput);
   assign grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & carryInput);
   assign grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
                   | (grp_p[2] & grp_p[1] & grp_p[0] & carryInput);

   assign prop        = &grp_p;
   assign gene        = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
                      | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0]);
   assign carryOutput = gene | (prop & carryInput);
endmodule

module cla16_multiword_seq #(
   parameter int WORDS = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [16*WORDS-1:0] a,
   input  logic [16*WORDS-1:0] b,
   input  logic                carryInput,
`ifdef CLA_SEQ_SUB_EN
   input  logic                sub,
`endif
   output logic                out_valid,
   input  logic                out_ready,
   output logic [16*WORDS-1:0] sum,
   output logic                carryOutput,
   output logic                busy
);
   localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                  state_reg;
   state_t                  state_next;
   logic [WORDS-1:0][15:0]  a_reg;
   logic [WORDS-1:0][15:0]  b_reg;
   logic [WORDS-1:0][15:0]  sum_reg;
   logic                    cin_reg;
   logic                    carry_reg;
   logic [IDX_W-1:0]        idx_reg;
   logic                    accept;

   logic [15:0] slice_a;
   logic [15:0] slice_b;
   logic        slice_cin;
   logic [15:0] slice_sum;
   logic        slice_cout;

   assign accept = (state_reg == IDLE) && in_valid;

`ifdef CLA_SEQ_SUB_EN
   logic sub_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sub_reg <= 1'b0;
      end else if (accept) begin
         sub_reg <= sub;
      end
   end

   // Subtraction is a + ~b + 1; the +1 is folded into the captured slice-0 carry.
   assign slice_b = b_reg[idx_reg] ^ {16{sub_reg}};
`else
   assign slice_b = b_reg[idx_reg];
`endif

   assign slice_a   = a_reg[idx_reg];
   assign slice_cin = (idx_reg == '0) ? cin_reg : carry_reg;

   cla16 u_cla16 (
      .a           (slice_a),
      .b           (slice_b),
      .carryInput  (slice_cin),
      .sum         (slice_sum),
      .carryOutput (slice_cout),
      .prop        (),
      .gene        ()
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (in_valid)             state_next = RUN;
         RUN:  if (idx_reg == LAST_IDX)  state_next = DONE;
         DONE: if (out_ready)            state_next = IDLE;
         default:                        state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_reg     <= '0;
         b_reg     <= '0;
         sum_reg   <= '0;
         cin_reg   <= 1'b0;
         carry_reg <= 1'b0;
         idx_reg   <= '0;
      end else if (accept) begin
         a_reg   <= a;
         b_reg   <= b;
         sum_reg <= '0;
         idx_reg <= '0;
`ifdef CLA_SEQ_SUB_EN
         cin_reg <= sub ? 1'b1 : carryInput;
`else
         cin_reg <= carryInput;
`endif
      end else if (state_reg == RUN) begin
         sum_reg[idx_reg] <= slice_sum;
         carry_reg        <= slice_cout;
         // The counter parks on the last slice rather than wrapping.
         if (idx_reg != LAST_IDX) begin
            idx_reg <= idx_reg + 1'b1;
         end
      end
   end

   // in_ready is gated by rst so every output reads 0 while reset is held.
   assign in_ready    = rst && (state_reg == IDLE);
   assign out_valid   = (state_reg == DONE);
   assign busy        = (state_reg == RUN) || (state_reg == DONE);
   assign sum         = sum_reg;
   assign carryOutput = carry_reg;
endmodule

// File: tb/tb_cla16_multiword_seq.sv
// Randomised scoreboard bench for cla16_multiword_seq: stimulus pushes model results, a monitor pops on each output handshake.
module tb_cla16_multiword_seq;
   localparam int WORDS = 4;
   localparam int W     = 16 * WORDS;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         carryInput = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] sum;
   logic         carryOutput;
   logic         busy;
`ifdef CLA_SEQ_SUB_EN
   logic         sub = 1'b0;
`endif

   int checks = 0;
   int errors = 0;
   int results = 0;
   logic [W:0] exp_q[$];

   always #5 clk = ~clk;

   cla16_multiword_seq #(.WORDS(WORDS)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .a           (a),
      .b           (b),
      .carryInput  (carryInput),
`ifdef CLA_SEQ_SUB_EN
      .sub         (sub),
`endif
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .sum         (sum),
      .carryOutput (carryOutput),
      .busy        (busy)
   );

   task automatic chk(input string name, input logic [W:0] act, input logic [W:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Reference: plain wide arithmetic, {carry, sum}.
   function automatic logic [W:0] model(input logic [W-1:0] xa, input logic [W-1:0] xb,
                                        input logic xcin, input logic xsub);
      if (xsub)
         return {(xa >= xb) ? 1'b1 : 1'b0, xa - xb};
      return {1'b0, xa} + {1'b0, xb} + (W+1)'(xcin);
   endfunction

   function automatic logic [W-1:0] rnd_operand();
      logic [W-1:0] r;
      for (int i = 0; i < WORDS; i++)
         r[16*i +: 16] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom());
      return r;
   endfunction

   // Monitor: one comparison per output handshake.
   always @(negedge clk) begin
      if (rst && out_valid && out_ready) begin
         results++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result actual=%0h required=none", {carryOutput, sum});
         end else begin
            logic [W:0] e;
            e = exp_q.pop_front();
            $display("RESULT %0d sum=%h cout=%0b expected=%h", results, sum, carryOutput, e);
            chk("result", {carryOutput, sum}, e);
         end
      end
   end

   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tcin,
                         input logic tsub, input int hold, input bit timing);
      logic [W:0] e;
      int k;
      k = 0;
      while (!in_ready && k < 50) begin
         @(posedge clk); #1;
         k++;
      end
      chk("in_ready_idle", (W+1)'(in_ready), (W+1)'(1));
      e = model(ta, tb_v, tcin, tsub);
      a = ta;
      b = tb_v;
      carryInput = tcin;
`ifdef CLA_SEQ_SUB_EN
      sub = tsub;
`endif
      in_valid  = 1'b1;
      out_ready = (hold == 0);
      exp_q.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0;
      k = 1;
      while (!out_valid && k < 20) begin
         if (timing) chk("in_ready_busy", (W+1)'(in_ready), '0);
         a = rnd_operand();
         b = rnd_operand();
         carryInput = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         k++;
      end
      chk("out_valid_seen", (W+1)'(out_valid), (W+1)'(1));
      if (!out_valid) return;
      if (timing) begin
         chk("latency", (W+1)'(k), (W+1)'(WORDS + 1));
         chk("in_ready_done", (W+1)'(in_ready), '0);
      end
      for (int h = 0; h < hold; h++) begin
         chk("hold_valid", (W+1)'(out_valid), (W+1)'(1));
         chk("hold_result", {carryOutput, sum}, e);
         chk("hold_in_ready", (W+1)'(in_ready), '0);
         in_valid = 1'b1;
         a = rnd_operand();
         @(posedge clk); #1;
         in_valid = 1'b0;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("in_ready_after_done", (W+1)'(in_ready), (W+1)'(1));
      chk("out_valid_dropped", (W+1)'(out_valid), '0);
   endtask

   initial begin
      int k;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_sum", {carryOutput, sum}, '0);
      chk("reset_out_valid", (W+1)'(out_valid), '0);
      chk("reset_busy", (W+1)'(busy), '0);
      chk("reset_in_ready", (W+1)'(in_ready), '0);
      rst = 1'b1;
      #1;
      chk("in_ready_release", (W+1)'(in_ready), (W+1)'(1));

      run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 0, 1'b1);
      run_op(64'h0, 64'h0, 1'b1, 1'b0, 0, 1'b1);
      run_op(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 1'b0, 0, 1'b1);
      run_op(64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b0, 3, 1'b1);

      // Abort an operation in its second RUN cycle; nothing is pushed for it.
      a = 64'h1;
      b = 64'h2;
      carryInput = 1'b0;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("busy_run", (W+1)'(busy), (W+1)'(1));
      rst = 1'b0;
      #1;
      chk("abort_sum", {carryOutput, sum}, '0);
      chk("abort_out_valid", (W+1)'(out_valid), '0);
      chk("abort_busy", (W+1)'(busy), '0);
      chk("abort_in_ready", (W+1)'(in_ready), '0);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("abort_in_ready_release", (W+1)'(in_ready), (W+1)'(1));
      run_op(64'd3, 64'd4, 1'b0, 1'b0, 0, 1'b1);

`ifdef CLA_SEQ_SUB_EN
      run_op(64'd5, 64'd7, 1'b0, 1'b1, 0, 1'b1);
      run_op(64'd7, 64'd5, 1'b1, 1'b1, 1, 1'b1);
`endif

      for (int n = 0; n < 40; n++) begin
         logic tsub;
`ifdef CLA_SEQ_SUB_EN
         tsub = 1'($urandom_range(0, 1));
`else
         tsub = 1'b0;
`endif
         run_op(rnd_operand(), rnd_operand(), 1'($urandom_range(0, 1)), tsub,
                $urandom_range(0, 3), 1'b1);
      end

      k = 0;
      while (exp_q.size() != 0 && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      chk("scoreboard_drained", (W+1)'(exp_q.size()), '0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
